// File: rtl/multi_hash_gen_if.sv
// Key-in / hash-out handshake bundle for multi_hash_gen.
// slave = hash generator side, master = key source / table controller side.
interface multi_hash_gen_if #(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned NUM_HASH = 2
);
  logic [KEY_W-1:0]          key;
  logic                      key_valid;
  logic                      key_ready;
  logic [NUM_HASH*IDX_W-1:0] hash;
  logic                      hash_valid;
  logic                      hash_ready;

  modport slave (
    input  key, key_valid, hash_ready,
    output key_ready, hash, hash_valid
  );

  modport master (
    output key, key_valid, hash_ready,
    input  key_ready, hash, hash_valid
  );
endinterface

// File: rtl/multi_hash_gen.sv
// Multi-choice bucket hash: h_i = floor(key / TABLE_DEPTH^i) mod TABLE_DEPTH,
// computed with one shared bit-serial restoring divider (KEY_W cycles per digit).
module multi_hash_gen #(
  parameter int unsigned KEY_W       = 32,
  parameter int unsigned TABLE_DEPTH = 11,
  parameter int unsigned NUM_HASH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  multi_hash_gen_if.slave hif
);

  localparam int unsigned IDX_W  = $clog2(TABLE_DEPTH);
  localparam int unsigned REM_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned DIG_W  = $clog2(NUM_HASH + 1);
  localparam int unsigned HASH_W = NUM_HASH * IDX_W;

  localparam logic [REM_W:0]   DIVISOR  = (REM_W + 1)'(TABLE_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_HASH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  state_e              state_q,    state_d;
  logic [KEY_W-1:0]    dividend_q, dividend_d;
  logic [REM_W-1:0]    rem_q,      rem_d;
  logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [DIG_W-1:0]    digit_q,    digit_d;
  logic [HASH_W-1:0]   hash_q,     hash_d;

  logic [REM_W:0]      rem_shift;
  logic [REM_W-1:0]    rem_step;
  logic                q_bit;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    bit_cnt_d  = bit_cnt_q;
    digit_d    = digit_q;
    hash_d     = hash_q;

    // One restoring step; the remainder stays below TABLE_DEPTH so the
    // subtraction result always fits back into REM_W bits.
    rem_shift = {rem_q, dividend_q[KEY_W-1]};
    if (rem_shift >= DIVISOR) begin
      rem_step = REM_W'(rem_shift - DIVISOR);
      q_bit    = 1'b1;
    end else begin
      rem_step = rem_shift[REM_W-1:0];
      q_bit    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hif.key_valid) begin
          dividend_d = hif.key;
          rem_d      = '0;
          digit_d    = '0;
          bit_cnt_d  = LAST_BIT;
          state_d    = DIV;
        end
      end

      DIV: begin
        // Quotient bits shift in at the LSB as dividend bits leave the MSB,
        // so after KEY_W steps the register already holds the next dividend.
        dividend_d = {dividend_q[KEY_W-2:0], q_bit};
        rem_d      = rem_step;
        bit_cnt_d  = bit_cnt_q - 1'b1;
        if (bit_cnt_q == '0) begin
          for (int unsigned i = 0; i < NUM_HASH; i++) begin
            if (digit_q == DIG_W'(i)) begin
              hash_d[i*IDX_W +: IDX_W] = rem_step[IDX_W-1:0];
            end
          end
          rem_d     = '0;
          bit_cnt_d = LAST_BIT;
          digit_d   = digit_q + 1'b1;
          if (digit_q == LAST_DIG) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (hif.hash_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      rem_q      <= '0;
      bit_cnt_q  <= '0;
      digit_q    <= '0;
      hash_q     <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      bit_cnt_q  <= bit_cnt_d;
      digit_q    <= digit_d;
      hash_q     <= hash_d;
    end
  end

  always_comb begin
    hif.key_ready  = (state_q == IDLE);
    hif.hash_valid = (state_q == DONE);
    hif.hash       = hash_q;
  end

endmodule

// File: tb/tb_multi_hash_gen.sv
// Randomised and directed bench for multi_hash_gen against an arithmetic
// reference (integer divide / modulo by powers of TABLE_DEPTH).
module tb_multi_hash_gen;

  localparam int unsigned KEY_W = 32;
  localparam int unsigned TD    = 11;
  localparam int unsigned IDX_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_hash_gen_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .NUM_HASH(2)) hif ();
  multi_hash_gen_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .NUM_HASH(4)) hif4 ();

  multi_hash_gen #(.KEY_W(KEY_W), .TABLE_DEPTH(TD), .NUM_HASH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  multi_hash_gen #(.KEY_W(KEY_W), .TABLE_DEPTH(TD), .NUM_HASH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  always @(posedge clk) begin
    if (rst_n && hif.key_valid && hif.key_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_hash(input longint unsigned k, input int nh);
    longint unsigned p;
    logic [63:0]     res;
    p   = 1;
    res = '0;
    for (int i = 0; i < nh; i++) begin
      res = res | (64'((k / p) % TD) << (i * IDX_W));
      p   = p * TD;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!hif.hash_valid && lat < 1000) begin
      if (hif.key_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_key(input logic [31:0] k, input string tag, input bit release_out);
    int lat;
    bit ok;
    check({tag, ":ready_in"}, 64'(hif.key_ready), 64'd1);
    hif.key       = k;
    hif.key_valid = 1'b1;
    tick();
    hif.key_valid = 1'b0;
    hif.key       = $urandom;
    wait_result(lat, ok);
    check({tag, ":latency"}, 64'(lat), 64'd64);
    check({tag, ":busy"}, 64'(ok), 64'd1);
    check({tag, ":hash"}, 64'(hif.hash), ref_hash(64'(k), 2));
    if (release_out) begin
      hif.hash_ready = 1'b1;
      tick();
      check({tag, ":valid_drop"}, 64'(hif.hash_valid), 64'd0);
      check({tag, ":ready_back"}, 64'(hif.key_ready), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] bk [4];
    int          lat;
    bit          ok;
    int          acc0;
    bit          hold_ok;

    rst_n           = 1'b0;
    hif.key         = '0;
    hif.key_valid   = 1'b0;
    hif.hash_ready  = 1'b1;
    hif4.key        = '0;
    hif4.key_valid  = 1'b0;
    hif4.hash_ready = 1'b1;
    repeat (3) tick();
    check("rst:key_ready", 64'(hif.key_ready), 64'd1);
    check("rst:hash_valid", 64'(hif.hash_valid), 64'd0);
    check("rst:hash", 64'(hif.hash), 64'd0);
    check("rst:hash4", 64'(hif4.hash), 64'd0);
    rst_n = 1'b1;
    tick();

    run_key(32'd279, "k279", 1'b1);
    run_key(32'd19, "k19", 1'b1);
    run_key(32'd8, "k8", 1'b1);
    run_key(32'd28, "k28", 1'b1);
    run_key(32'hFFFF_FFFF, "kmax", 1'b1);
    run_key(32'd10, "k10", 1'b1);
    run_key(32'd0, "k0", 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_key((i % 3 == 0) ? 32'($urandom_range(0, 200)) : $urandom, "rand", 1'b1);
    end

    // Four-digit variant
    hif4.key       = 32'd279;
    hif4.key_valid = 1'b1;
    tick();
    hif4.key_valid = 1'b0;
    lat = 0;
    while (!hif4.hash_valid && lat < 1000) begin
      tick();
      lat++;
    end
    check("nh4:latency", 64'(lat), 64'd128);
    check("nh4:hash", 64'(hif4.hash), ref_hash(64'd279, 4));
    tick();
    check("nh4:valid_drop", 64'(hif4.hash_valid), 64'd0);

    // Backpressure with a rejected key_valid pulse
    hif.hash_ready = 1'b0;
    run_key(32'd279, "bp", 1'b0);
    acc0    = acc_cnt;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hif.key_valid = (i == 5);
      hif.key       = 32'd19;
      tick();
      if (hif.hash !== 8'h34 || !hif.hash_valid || hif.key_ready) hold_ok = 1'b0;
    end
    hif.key_valid = 1'b0;
    check("bp:hold_stable", 64'(hold_ok), 64'd1);
    check("bp:no_accept", 64'(acc_cnt - acc0), 64'd0);
    check("bp:hash", 64'(hif.hash), ref_hash(64'd279, 2));
    hif.hash_ready = 1'b1;
    tick();
    check("bp:valid_drop", 64'(hif.hash_valid), 64'd0);
    check("bp:ready_back", 64'(hif.key_ready), 64'd1);

    // Reset in the middle of a division
    hif.key       = 32'd279;
    hif.key_valid = 1'b1;
    tick();
    hif.key_valid = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst:hash_valid", 64'(hif.hash_valid), 64'd0);
    check("midrst:hash", 64'(hif.hash), 64'd0);
    check("midrst:key_ready", 64'(hif.key_ready), 64'd1);
    run_key(32'd28, "midrst_k28", 1'b1);

    // Back-to-back with key_valid held high
    for (int i = 0; i < 4; i++) bk[i] = $urandom;
    acc0          = acc_cnt;
    hif.key       = bk[0];
    hif.key_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      hif.key       = (i + 1 < 4) ? bk[(i + 1) % 4] : 32'd0;
      hif.key_valid = (i + 1 < 4);
      wait_result(lat, ok);
      check("b2b:latency", 64'(lat), 64'd64);
      check("b2b:busy", 64'(ok), 64'd1);
      check("b2b:hash", 64'(hif.hash), ref_hash(64'(bk[i]), 2));
      tick();
      check("b2b:idle_gap", 64'(hif.key_ready), 64'd1);
      if (i + 1 < 4) begin
        tick();
        check("b2b:accepted", 64'(hif.key_ready), 64'd0);
      end
    end
    hif.key_valid = 1'b0;
    tick();
    check("b2b:accept_count", 64'(acc_cnt - acc0), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
